// File: rtl/psram_rect_fill.sv
// Rectangle fill engine: writes one constant word over a WIDTH x HEIGHT
// block of the frame buffer through the front-end application-2 port.
module psram_rect_fill #(
  parameter int ADDR_W      = 23,
  parameter int DIM_W       = 10,
  parameter int LINE_STRIDE = 400
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ctrlr_good,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  input  logic [15:0]       fill_data,
  input  logic              fill_ub,
  input  logic              fill_lb,
  input  logic              op_begun,
  input  logic              op_finished,
  output logic              wr,
  output logic              rd,
  output logic              burst,
  output logic              ub,
  output logic              lb,
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       data_out,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GOOD,
    ISSUE,
    WAIT_FIN,
    DONE
  } state_t;

  state_t            state;
  logic [DIM_W-1:0]  w_q;
  logic [DIM_W-1:0]  h_q;
  logic [DIM_W-1:0]  col;
  logic [DIM_W-1:0]  row;
  logic [ADDR_W-1:0] row_addr;
  logic              abort_q;
  logic              abort_now;
  logic              last_col;
  logic              last_row;

  assign rd        = 1'b0;
  assign burst     = 1'b0;
  assign abort_now = abort | abort_q;
  assign last_col  = (col == w_q - 1'b1);
  assign last_row  = (row == h_q - 1'b1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wr       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      addr     <= '0;
      data_out <= '0;
      ub       <= 1'b0;
      lb       <= 1'b0;
      w_q      <= '0;
      h_q      <= '0;
      col      <= '0;
      row      <= '0;
      row_addr <= '0;
      abort_q  <= 1'b0;
    end else begin
      done <= 1'b0;
      // abort is remembered so it can take effect after an accepted write
      if (abort && state != IDLE && state != DONE)
        abort_q <= 1'b1;
      unique case (state)
        IDLE: begin
          if (start) begin
            addr     <= base_addr;
            row_addr <= base_addr;
            w_q      <= width;
            h_q      <= height;
            data_out <= fill_data;
            ub       <= fill_ub;
            lb       <= fill_lb;
            col      <= '0;
            row      <= '0;
            busy     <= 1'b1;
            aborted  <= 1'b0;
            abort_q  <= 1'b0;
            if (width == '0 || height == '0)
              state <= DONE;
            else
              state <= WAIT_GOOD;
          end
        end
        WAIT_GOOD: begin
          if (abort_now) begin
            aborted <= 1'b1;
            state   <= DONE;
          end else if (ctrlr_good) begin
            wr    <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          // an accepted write wins over a simultaneous abort
          if (op_begun) begin
            wr    <= 1'b0;
            state <= WAIT_FIN;
          end else if (abort_now) begin
            wr      <= 1'b0;
            aborted <= 1'b1;
            state   <= DONE;
          end
        end
        WAIT_FIN: begin
          if (op_finished) begin
            if (last_col) begin
              col      <= '0;
              row      <= row + 1'b1;
              row_addr <= row_addr + ADDR_W'(LINE_STRIDE);
              addr     <= row_addr + ADDR_W'(LINE_STRIDE);
            end else begin
              col  <= col + 1'b1;
              addr <= addr + 1'b1;
            end
            if (last_col && last_row) begin
              state <= DONE;
            end else if (abort_now) begin
              aborted <= 1'b1;
              state   <= DONE;
            end else begin
              wr    <= 1'b1;
              state <= ISSUE;
            end
          end
        end
        DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          abort_q <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_rect_fill.sv
// Scoreboard bench for psram_rect_fill with a simple front-end model.
module tb_psram_rect_fill;

  logic        clk = 0;
  logic        reset;
  logic        ctrlr_good;
  logic        start;
  logic        abort;
  logic [22:0] base_addr;
  logic [9:0]  width;
  logic [9:0]  height;
  logic [15:0] fill_data;
  logic        fill_ub;
  logic        fill_lb;
  logic        op_begun;
  logic        op_finished;
  logic        wr, rd, burst, ub, lb;
  logic [22:0] addr;
  logic [15:0] data_out;
  logic        busy, done, aborted;

  typedef struct {
    logic [22:0] a;
    logic [15:0] d;
    logic        u;
    logic        l;
  } wr_t;

  wr_t q[$];
  int  vec = 0;
  int  errs = 0;
  int  nwr = 0;
  int  begun_dly = 0;

  always #5 clk = ~clk;

  psram_rect_fill dut (
    .clk(clk), .reset(reset), .ctrlr_good(ctrlr_good),
    .start(start), .abort(abort), .base_addr(base_addr),
    .width(width), .height(height), .fill_data(fill_data),
    .fill_ub(fill_ub), .fill_lb(fill_lb),
    .op_begun(op_begun), .op_finished(op_finished),
    .wr(wr), .rd(rd), .burst(burst), .ub(ub), .lb(lb),
    .addr(addr), .data_out(data_out),
    .busy(busy), .done(done), .aborted(aborted)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_wr(logic [22:0] a, logic [15:0] d, logic u, logic l);
    wr_t e;
    e.a = a; e.d = d; e.u = u; e.l = l;
    q.push_back(e);
  endtask

  // front-end: accept after begun_dly cycles, finish the cycle after
  initial begin
    int n;
    op_begun = 0;
    op_finished = 0;
    forever begin
      @(negedge clk);
      op_finished = 0;
      if (wr && !reset) begin
        n = 0;
        while (wr && n < begun_dly) begin
          @(negedge clk);
          n++;
        end
        if (wr) begin
          op_begun = 1;
          @(negedge clk);
          op_begun = 0;
          op_finished = 1;
        end
      end
    end
  end

  // monitor: compare each accepted write against the scoreboard
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      #1;
      if (wr && op_begun) begin
        nwr++;
        if (q.size() == 0) begin
          check("unexpected_write", {9'd0, addr}, 32'hFFFFFFFF);
        end else begin
          e = q.pop_front();
          check("wr_addr", {9'd0, addr}, {9'd0, e.a});
          check("wr_data", {14'd0, data_out, ub, lb},
                {14'd0, e.d, e.u, e.l});
        end
      end
    end
  end

  task automatic start_fill(logic [22:0] b, logic [9:0] w, logic [9:0] h,
                            logic [15:0] d, logic u, logic l);
    @(negedge clk);
    base_addr = b; width = w; height = h;
    fill_data = d; fill_ub = u; fill_lb = l;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(string name, int lim);
    int n;
    n = 0;
    while (!done && n < lim) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, {31'd0, done}, 32'd1);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic        ok;
    logic [22:0] a0;
    int          w0;
    reset = 1; ctrlr_good = 1; start = 0; abort = 0;
    base_addr = 0; width = 0; height = 0;
    fill_data = 0; fill_ub = 0; fill_lb = 0;
    repeat (3) @(negedge clk);
    check("rst_out", {wr, busy, done, aborted, ub, lb, rd, burst},
          32'd0);
    check("rst_addr", {9'd0, addr}, 32'd0);
    check("rst_data", {16'd0, data_out}, 32'd0);
    reset = 0;

    // 3x2 fill, row stride 400
    expect_wr(23'h100, 16'hA5C3, 1, 1);
    expect_wr(23'h101, 16'hA5C3, 1, 1);
    expect_wr(23'h102, 16'hA5C3, 1, 1);
    expect_wr(23'h290, 16'hA5C3, 1, 1);
    expect_wr(23'h291, 16'hA5C3, 1, 1);
    expect_wr(23'h292, 16'hA5C3, 1, 1);
    start_fill(23'h100, 3, 2, 16'hA5C3, 1, 1);
    check("t1_wr_pre", {31'd0, wr}, 32'd0);
    @(negedge clk);
    check("t1_wr_rise", {31'd0, wr}, 32'd1);
    wait_done("t1", 200);
    check("t1_left", q.size(), 0);
    check("t1_count", nwr, 6);
    check("t1_aborted", {31'd0, aborted}, 32'd0);

    // zero width
    w0 = nwr;
    start_fill(23'h500, 0, 5, 16'h1111, 1, 1);
    check("t2_done_early", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_busy", {31'd0, busy}, 32'd0);
    check("t2_aborted", {31'd0, aborted}, 32'd0);
    repeat (3) @(negedge clk);
    check("t2_nowr", nwr, w0);

    // controller not ready for 50 cycles
    ctrlr_good = 0;
    expect_wr(23'h2000, 16'h0F0F, 1, 0);
    expect_wr(23'h2001, 16'h0F0F, 1, 0);
    expect_wr(23'h2190, 16'h0F0F, 1, 0);
    expect_wr(23'h2191, 16'h0F0F, 1, 0);
    start_fill(23'h2000, 2, 2, 16'h0F0F, 1, 0);
    ok = 1;
    repeat (50) begin
      @(negedge clk);
      if (wr) ok = 0;
    end
    check("t3_wr_held_low", {31'd0, ok}, 32'd1);
    ctrlr_good = 1;
    wait_done("t3", 200);
    check("t3_left", q.size(), 0);

    // slow accept, ignored second start
    begun_dly = 7;
    w0 = nwr;
    expect_wr(23'h3000, 16'hBEEF, 0, 1);
    expect_wr(23'h3001, 16'hBEEF, 0, 1);
    start_fill(23'h3000, 2, 1, 16'hBEEF, 0, 1);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (wr) ok = 1;
    end
    check("t4_wr_seen", {31'd0, ok}, 32'd1);
    a0 = addr;
    ok = 1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 2) begin
        base_addr = 23'h5000; start = 1;
      end
      if (i == 3) start = 0;
      if (!wr || addr !== a0 || data_out !== 16'hBEEF) ok = 0;
    end
    check("t4_hold", {31'd0, ok}, 32'd1);
    wait_done("t4", 200);
    repeat (5) @(negedge clk);
    check("t4_count", nwr - w0, 2);
    check("t4_idle", {31'd0, busy}, 32'd0);
    check("t4_left", q.size(), 0);
    begun_dly = 0;

    // abort during the second write of a 4x4
    w0 = nwr;
    expect_wr(23'h1000, 16'h5A5A, 1, 1);
    expect_wr(23'h1001, 16'h5A5A, 1, 1);
    start_fill(23'h1000, 4, 4, 16'h5A5A, 1, 1);
    for (int i = 0; i < 50 && nwr - w0 < 2; i++) begin
      @(negedge clk);
      #2;
    end
    abort = 1;
    @(negedge clk);
    abort = 0;
    wait_done("t5", 50);
    check("t5_aborted", {31'd0, aborted}, 32'd1);
    repeat (5) @(negedge clk);
    check("t5_count", nwr - w0, 2);
    check("t5_left", q.size(), 0);

    // address wrap
    expect_wr(23'h7FFFFE, 16'hC0DE, 0, 1);
    expect_wr(23'h7FFFFF, 16'hC0DE, 0, 1);
    expect_wr(23'h000000, 16'hC0DE, 0, 1);
    expect_wr(23'h000001, 16'hC0DE, 0, 1);
    start_fill(23'h7FFFFE, 4, 1, 16'hC0DE, 0, 1);
    wait_done("t6", 100);
    check("t6_left", q.size(), 0);
    check("t6_aborted", {31'd0, aborted}, 32'd0);

    // reset mid-fill
    w0 = nwr;
    expect_wr(23'h4000, 16'h7777, 1, 1);
    expect_wr(23'h4001, 16'h7777, 1, 1);
    start_fill(23'h4000, 4, 4, 16'h7777, 1, 1);
    for (int i = 0; i < 50 && nwr - w0 < 2; i++) begin
      @(negedge clk);
      #2;
    end
    reset = 1;
    @(negedge clk);
    check("t7_rst_wr", {31'd0, wr}, 32'd0);
    check("t7_rst_busy", {31'd0, busy}, 32'd0);
    reset = 0;
    repeat (20) @(negedge clk);
    check("t7_count", nwr - w0, 2);
    check("t7_idle", {30'd0, wr, busy}, 32'd0);
    check("t7_left", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
